// File: rtl/sa_pkg.sv
// Shared types and latency constants for the systolic-array matmul sequencer.
// The command FSM uses SEQ_TOTAL_CYCLES for its interrupt timeout.
package sa_pkg;

    localparam int unsigned SA_N  = 8;
    localparam int unsigned SA_IW = $clog2(SA_N);
    localparam int unsigned SA_CW = $clog2(3 * SA_N);

    localparam int unsigned SEQ_FEED_CYCLES  = 2 * SA_N - 1;
    localparam int unsigned SEQ_FLUSH_CYCLES = SA_N;
    localparam int unsigned SEQ_TOTAL_CYCLES = 3 * SA_N;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_e;

endpackage

// File: rtl/sa_skew_lane.sv
// One lane of the diagonal operand skew: lane LANE sees element t-LANE while
// that index lies inside the row, and is fed zero otherwise.
module sa_skew_lane #(
    parameter int unsigned N    = 8,
    parameter int unsigned IW   = 3,
    parameter int unsigned CW   = 5,
    parameter int unsigned LANE = 0
) (
    input  logic [CW-1:0] t,
    input  logic          in_feed,
    output logic          valid_c,
    output logic [IW-1:0] idx_c
);

    localparam logic signed [CW:0] LANE_S = (CW + 1)'(LANE);
    localparam logic signed [CW:0] LAST_S = (CW + 1)'(N - 1);

    logic signed [CW:0] k;

    // One extra bit keeps t-LANE signed without wrapping.
    always_comb begin
        k       = $signed({1'b0, t}) - LANE_S;
        valid_c = in_feed && !k[CW] && (k <= LAST_S);
        idx_c   = valid_c ? k[IW-1:0] : '0;
    end

endmodule

// File: rtl/sa_matmul_sequencer.sv
// Sequences one matrix multiply on the NxN systolic array: clear accumulators,
// feed skewed operand indices, flush the pipeline, then hold DONE.
module sa_matmul_sequencer
    import sa_pkg::*;
#(
    parameter int unsigned N  = SA_N,
    parameter int unsigned IW = $clog2(N),
    parameter int unsigned CW = $clog2(3 * N)
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            START,
    output logic            BUSY,
    output logic            DONE,
    output logic            ACC_CLEAR,
    output logic            ACC_EN,
    output logic [N-1:0]    FEED_VALID,
    output logic [N*IW-1:0] FEED_IDX
);

    localparam logic [CW-1:0] FEED_LAST  = CW'(2 * N - 2);
    localparam logic [CW-1:0] FLUSH_LAST = CW'(N - 1);

    seq_state_e        state;
    seq_state_e        state_nxt;
    logic [CW-1:0]     t;
    logic [CW-1:0]     t_nxt;
    logic              feed_nxt_c;
    logic              busy_nxt;
    logic              done_nxt;
    logic              clear_nxt;
    logic              en_nxt;
    logic [N-1:0]      lane_valid_c;
    logic [N*IW-1:0]   lane_idx_c;

    // Next state and phase counter; dropping START aborts any busy phase.
    always_comb begin
        state_nxt = state;
        t_nxt     = t;
        unique case (state)
            ST_IDLE: begin
                t_nxt = '0;
                if (START) state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                t_nxt     = '0;
                state_nxt = START ? ST_FEED : ST_IDLE;
            end
            ST_FEED: begin
                if (!START) begin
                    state_nxt = ST_IDLE;
                    t_nxt     = '0;
                end else if (t == FEED_LAST) begin
                    state_nxt = ST_FLUSH;
                    t_nxt     = '0;
                end else begin
                    t_nxt = t + CW'(1);
                end
            end
            ST_FLUSH: begin
                if (!START) begin
                    state_nxt = ST_IDLE;
                    t_nxt     = '0;
                end else if (t == FLUSH_LAST) begin
                    state_nxt = ST_DONE;
                    t_nxt     = '0;
                end else begin
                    t_nxt = t + CW'(1);
                end
            end
            ST_DONE: begin
                t_nxt = '0;
                if (!START) state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
                t_nxt     = '0;
            end
        endcase
    end

    // Output decode of the upcoming state so the registered outputs track it.
    always_comb begin
        feed_nxt_c = (state_nxt == ST_FEED);
        busy_nxt   = (state_nxt == ST_CLEAR) || (state_nxt == ST_FEED) || (state_nxt == ST_FLUSH);
        done_nxt   = (state_nxt == ST_DONE);
        clear_nxt  = (state_nxt == ST_CLEAR);
        en_nxt     = (state_nxt == ST_FEED) || (state_nxt == ST_FLUSH);
    end

    for (genvar r = 0; r < N; r++) begin : g_lane
        sa_skew_lane #(
            .N    (N),
            .IW   (IW),
            .CW   (CW),
            .LANE (r)
        ) u_lane (
            .t       (t_nxt),
            .in_feed (feed_nxt_c),
            .valid_c (lane_valid_c[r]),
            .idx_c   (lane_idx_c[r*IW +: IW])
        );
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= ST_IDLE;
            t          <= '0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            ACC_CLEAR  <= 1'b0;
            ACC_EN     <= 1'b0;
            FEED_VALID <= '0;
            FEED_IDX   <= '0;
        end else begin
            state      <= state_nxt;
            t          <= t_nxt;
            BUSY       <= busy_nxt;
            DONE       <= done_nxt;
            ACC_CLEAR  <= clear_nxt;
            ACC_EN     <= en_nxt;
            FEED_VALID <= lane_valid_c;
            FEED_IDX   <= lane_idx_c;
        end
    end

endmodule

// File: tb/tb_sa_matmul_sequencer.sv
// Self-checking bench: run-position reference model, per-lane index scoreboard
// and a behavioural output-stationary array fed by the sequencer.
module tb_sa_matmul_sequencer;

    localparam int N     = 8;
    localparam int IW    = 3;
    localparam int CW    = 5;
    localparam int TOTAL = 3 * N;

    logic            CLK;
    logic            RST_N;
    logic            START;
    logic            BUSY;
    logic            DONE;
    logic            ACC_CLEAR;
    logic            ACC_EN;
    logic [N-1:0]    FEED_VALID;
    logic [N*IW-1:0] FEED_IDX;

    sa_matmul_sequencer #(.N(N), .IW(IW), .CW(CW)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .START      (START),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .ACC_CLEAR  (ACC_CLEAR),
        .ACC_EN     (ACC_EN),
        .FEED_VALID (FEED_VALID),
        .FEED_IDX   (FEED_IDX)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;
    int pos   = -1;        // -1 idle, 0 clear, 1..2N-1 feed, 2N..3N-1 flush, 3N done
    int done_rises = 0;
    logic done_q = 1'b0;

    int a_m [N][N];
    int w_m [N][N];
    int acc [N][N];
    int ap  [N][N];
    int wp  [N][N];
    int lane_cnt [N];
    bit lane_ok  [N];

    task automatic chk(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void expect_outs(input int p, output logic eb, output logic ed,
                                        output logic ec, output logic ee,
                                        output logic [N-1:0] ev, output logic [N*IW-1:0] ei);
        eb = (p >= 0) && (p < TOTAL);
        ed = (p == TOTAL);
        ec = (p == 0);
        ee = (p >= 1) && (p < TOTAL);
        ev = '0;
        ei = '0;
        if (p >= 1 && p <= 2 * N - 1) begin
            for (int r = 0; r < N; r++) begin
                int k;
                k = (p - 1) - r;
                if (k >= 0 && k < N) begin
                    ev[r] = 1'b1;
                    ei[r*IW +: IW] = IW'(k);
                end
            end
        end
    endfunction

    task automatic check_result();
        for (int r = 0; r < N; r++) begin
            chk("lane_count", lane_cnt[r], N);
            chk("lane_order", lane_ok[r], 1);
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                int g;
                g = 0;
                for (int k = 0; k < N; k++) g += a_m[i][k] * w_m[j][k];
                chk("c_elem", acc[i][j], g);
            end
    endtask

    // The array latches at the next edge whatever the sequencer shows now.
    task automatic array_step();
        int na [N][N];
        int nw [N][N];
        if (ACC_CLEAR) begin
            for (int i = 0; i < N; i++) begin
                lane_cnt[i] = 0;
                lane_ok[i]  = 1'b1;
                for (int j = 0; j < N; j++) begin
                    acc[i][j] = 0; ap[i][j] = 0; wp[i][j] = 0;
                    a_m[i][j] = int'($urandom_range(0, 15));
                    w_m[i][j] = int'($urandom_range(0, 15));
                end
            end
        end else if (ACC_EN) begin
            for (int r = 0; r < N; r++)
                if (FEED_VALID[r]) begin
                    if (int'(FEED_IDX[r*IW +: IW]) != lane_cnt[r]) lane_ok[r] = 1'b0;
                    lane_cnt[r]++;
                end
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    int ai;
                    int wi;
                    if (j == 0) ai = FEED_VALID[i] ? a_m[i][FEED_IDX[i*IW +: IW]] : 0;
                    else        ai = ap[i][j-1];
                    if (i == 0) wi = FEED_VALID[j] ? w_m[j][FEED_IDX[j*IW +: IW]] : 0;
                    else        wi = wp[i-1][j];
                    acc[i][j] += ai * wi;
                    na[i][j] = ai;
                    nw[i][j] = wi;
                end
            ap = na;
            wp = nw;
        end
    endtask

    task automatic tick(input logic s);
        logic eb, ed, ec, ee;
        logic [N-1:0] ev;
        logic [N*IW-1:0] ei;
        START = s;
        @(posedge CLK);
        if (pos < 0) begin
            if (s) pos = 0;
        end else if (pos < TOTAL) begin
            pos = s ? pos + 1 : -1;
        end else if (!s) begin
            pos = -1;
        end
        #1;
        expect_outs(pos, eb, ed, ec, ee, ev, ei);
        chk("busy", BUSY, eb);
        chk("done", DONE, ed);
        chk("acc_clear", ACC_CLEAR, ec);
        chk("acc_en", ACC_EN, ee);
        chk("feed_valid", FEED_VALID, ev);
        chk("feed_idx", FEED_IDX, ei);
        if (DONE && !done_q) begin
            done_rises++;
            check_result();
        end
        done_q = DONE;
        array_step();
        @(negedge CLK);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, BUSY, 0);
        chk({tag, "_done"}, DONE, 0);
        chk({tag, "_clear"}, ACC_CLEAR, 0);
        chk({tag, "_en"}, ACC_EN, 0);
        chk({tag, "_valid"}, FEED_VALID, 0);
        chk({tag, "_idx"}, FEED_IDX, 0);
    endtask

    initial begin
        int bl;
        int r0;
        logic s;
        RST_N = 1'b0;
        START = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge CLK);
        RST_N = 1'b1;
        tick(1'b0);

        // Nominal run, then release
        bl = 0;
        r0 = done_rises;
        for (int i = 0; i < TOTAL + 6; i++) begin
            tick(1'b1);
            if (BUSY) bl++;
        end
        chk("busy_len", bl, TOTAL);
        chk("nominal_done_rises", done_rises - r0, 1);
        for (int i = 0; i < 3; i++) tick(1'b0);

        // Abort at FEED t=5, then a clean restart
        r0 = done_rises;
        for (int i = 0; i < 7; i++) tick(1'b1);
        tick(1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0);
        chk("abort_no_done", done_rises - r0, 0);
        for (int i = 0; i < TOTAL + 3; i++) tick(1'b1);
        chk("restart_done_rises", done_rises - r0, 1);
        tick(1'b0);

        // Asynchronous reset mid-FLUSH, between edges
        for (int i = 0; i < 2 * N + 4; i++) tick(1'b1);
        START = 1'b0;
        #2;
        RST_N = 1'b0;
        #1;
        check_all_zero("async_rst");
        pos    = -1;
        done_q = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        tick(1'b0);
        bl = 0;
        r0 = done_rises;
        for (int i = 0; i < TOTAL + 3; i++) begin
            tick(1'b1);
            if (BUSY) bl++;
        end
        chk("post_rst_busy_len", bl, TOTAL);
        chk("post_rst_done_rises", done_rises - r0, 1);
        tick(1'b0);

        // START held for 40 cycles: exactly one run
        r0 = done_rises;
        for (int i = 0; i < 40; i++) tick(1'b1);
        for (int i = 0; i < 2; i++) tick(1'b0);
        chk("retrigger_done_rises", done_rises - r0, 1);

        // Random START levels
        s = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) s = ~s;
            tick(s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
